id_branch_ctrl: RTL and testbench

- Decode-stage branch/jump resolution controller for the RV32I pipeline.
- Accepts a decoded control-transfer instruction and waits while its source operands are hazarded.
- Evaluates the branch condition and drives a branch_gen instance (PC+imm or rs1+imm) to form the target.
- Sequences the fetch redirect and the IF/ID flush, keeps branch/taken statistics counters, and flags misaligned targets.

---
 rtl/id_branch_ctrl_pkg.sv | 26 ++
 rtl/id_branch_ctrl_if.sv | 41 ++++
 rtl/id_branch_ctrl_branch_gen.sv | 21 ++
 rtl/id_branch_ctrl.sv | 115 +++++++++++
 tb/tb_id_branch_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/id_branch_ctrl_pkg.sv
// Shared types for the decode-stage branch controller: control-transfer classes,
// target-generation operand selects and the controller state encoding.
package id_branch_ctrl_pkg;

   typedef enum logic [3:0] {
      BrNone = 4'd0,
      BrJal  = 4'd1,
      BrJalr = 4'd2,
      BrBeq  = 4'd3,
      BrBne  = 4'd4,
      BrBlt  = 4'd5,
      BrBge  = 4'd6,
      BrBltu = 4'd7,
      BrBgeu = 4'd8
   } br_type_e;

   localparam logic PcRelative = 1'b0;
   localparam logic RegOffset  = 1'b1;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StWaitOpnd = 2'd1,
      StRedirect = 2'd2
   } br_state_e;

endpackage

// File: rtl/id_branch_ctrl_if.sv
// Decode-stage to branch-controller bus: the ID instruction and operands in,
// stall/redirect/flush controls and statistics out.
interface id_branch_ctrl_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32
);
   import id_branch_ctrl_pkg::*;

   logic             id_valid;
   br_type_e         id_br_type;
   logic [XLEN-1:0]  id_pc;
   logic [XLEN-1:0]  id_imm;
   logic [XLEN-1:0]  rs1_data;
   logic [XLEN-1:0]  rs2_data;
   logic             rs1_hazard;
   logic             rs2_hazard;
   logic             ex_stall;
   logic             id_stall;
   logic             pc_redirect;
   logic [XLEN-1:0]  redirect_target;
   logic             flush_ifid;
   logic [XLEN-1:0]  link_pc;
   logic             misalign_exc;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] taken_cnt;

   modport master (
      output id_valid, id_br_type, id_pc, id_imm, rs1_data, rs2_data,
             rs1_hazard, rs2_hazard, ex_stall,
      input  id_stall, pc_redirect, redirect_target, flush_ifid, link_pc,
             misalign_exc, branch_cnt, taken_cnt
   );

   modport slave (
      input  id_valid, id_br_type, id_pc, id_imm, rs1_data, rs2_data,
             rs1_hazard, rs2_hazard, ex_stall,
      output id_stall, pc_redirect, redirect_target, flush_ifid, link_pc,
             misalign_exc, branch_cnt, taken_cnt
   );

endinterface

// File: rtl/id_branch_ctrl_branch_gen.sv
// Branch target adder: PC+imm for branches/JAL, rs1+imm with bit 0 cleared for JALR.
module branch_gen
   import id_branch_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            branch_op,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] target
);

   logic [XLEN-1:0] sum;

   always_comb begin
      sum    = (branch_op == RegOffset) ? (rs1 + imm) : (pc + imm);
      target = (branch_op == RegOffset) ? {sum[XLEN-1:1], 1'b0} : sum;
   end

endmodule

// File: rtl/id_branch_ctrl.sv
// Decode-stage branch/jump resolution: waits out operand hazards, evaluates the
// condition, then sequences PC redirect + IF/ID flush or a misaligned-target strobe.
module id_branch_ctrl
   import id_branch_ctrl_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32
) (
   input  logic          clk,
   input  logic          resetn,
   id_branch_ctrl_if.slave bus
);

   br_state_e        state_q;
   logic             pc_redirect_q;
   logic             flush_ifid_q;
   logic             misalign_q;
   logic [XLEN-1:0]  target_q;
   logic [CNT_W-1:0] branch_cnt_q;
   logic [CNT_W-1:0] taken_cnt_q;

   logic            active, need_rs1, need_rs2, hazard, eval, resolve, taken, aligned;
   logic            branch_op;
   logic [XLEN-1:0] target;

   always_comb begin
      active   = bus.id_valid && (bus.id_br_type != BrNone);
      need_rs1 = (bus.id_br_type != BrJal);
      need_rs2 = (bus.id_br_type != BrJal) && (bus.id_br_type != BrJalr);
      hazard   = (need_rs1 && bus.rs1_hazard) || (need_rs2 && bus.rs2_hazard);
      eval     = active && !bus.ex_stall;
      resolve  = eval && !hazard;
      branch_op = (bus.id_br_type == BrJalr) ? RegOffset : PcRelative;
      unique case (bus.id_br_type)
         BrBeq:   taken = (bus.rs1_data == bus.rs2_data);
         BrBne:   taken = (bus.rs1_data != bus.rs2_data);
         BrBlt:   taken = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
         BrBge:   taken = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
         BrBltu:  taken = (bus.rs1_data <  bus.rs2_data);
         BrBgeu:  taken = (bus.rs1_data >= bus.rs2_data);
         BrJal,
         BrJalr:  taken = 1'b1;
         default: taken = 1'b0;
      endcase
      aligned = (target[1:0] == 2'b00);
   end

   branch_gen #(
      .XLEN(XLEN)
   ) u_branch_gen (
      .branch_op(branch_op),
      .pc       (bus.id_pc),
      .rs1      (bus.rs1_data),
      .imm      (bus.id_imm),
      .target   (target)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= StIdle;
         pc_redirect_q <= 1'b0;
         flush_ifid_q  <= 1'b0;
         misalign_q    <= 1'b0;
         target_q      <= '0;
         branch_cnt_q  <= '0;
         taken_cnt_q   <= '0;
      end else begin
         pc_redirect_q <= 1'b0;
         flush_ifid_q  <= 1'b0;
         misalign_q    <= 1'b0;
         unique case (state_q)
            StIdle, StWaitOpnd: begin
               if (resolve) begin
                  state_q      <= StIdle;
                  branch_cnt_q <= branch_cnt_q + CNT_W'(1);
                  if (taken) begin
                     taken_cnt_q <= taken_cnt_q + CNT_W'(1);
                     if (aligned) begin
                        target_q      <= target;
                        pc_redirect_q <= 1'b1;
                        flush_ifid_q  <= 1'b1;
                        state_q       <= StRedirect;
                     end else begin
                        misalign_q <= 1'b1;
                     end
                  end
               end else if (eval) begin
                  state_q <= StWaitOpnd;
               end else if (!active) begin
                  // Instruction vanished while waiting: nothing left to resolve.
                  state_q <= StIdle;
               end
            end
            StRedirect: state_q <= StIdle;
            default:    state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      unique case (state_q)
         StIdle:     bus.id_stall = eval && hazard;
         StWaitOpnd: bus.id_stall = !resolve;
         default:    bus.id_stall = 1'b0;
      endcase
      bus.pc_redirect     = pc_redirect_q;
      bus.flush_ifid      = flush_ifid_q;
      bus.misalign_exc    = misalign_q;
      bus.redirect_target = target_q;
      bus.branch_cnt      = branch_cnt_q;
      bus.taken_cnt       = taken_cnt_q;
      bus.link_pc         = bus.id_pc + XLEN'(4);
   end

endmodule

// File: tb/tb_id_branch_ctrl.sv
// Directed bench for id_branch_ctrl: a 32-bit-counter instance plus a 2-bit-counter
// instance used to observe counter wrap.
module tb_id_branch_ctrl;
   import id_branch_ctrl_pkg::*;

   logic clk;
   logic resetn;
   logic resetn_s;
   int   checks = 0;
   int   errors = 0;

   id_branch_ctrl_if #(.XLEN(32), .CNT_W(32)) bus ();
   id_branch_ctrl_if #(.XLEN(32), .CNT_W(2))  bus_s ();

   id_branch_ctrl #(.XLEN(32), .CNT_W(32)) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus)
   );

   id_branch_ctrl #(.XLEN(32), .CNT_W(2)) dut_s (
      .clk   (clk),
      .resetn(resetn_s),
      .bus   (bus_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic v, input br_type_e t, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [31:0] r1, input logic [31:0] r2,
                      input logic h1, input logic h2, input logic es);
      bus.id_valid   = v;   bus_s.id_valid   = v;
      bus.id_br_type = t;   bus_s.id_br_type = t;
      bus.id_pc      = pc;  bus_s.id_pc      = pc;
      bus.id_imm     = imm; bus_s.id_imm     = imm;
      bus.rs1_data   = r1;  bus_s.rs1_data   = r1;
      bus.rs2_data   = r2;  bus_s.rs2_data   = r2;
      bus.rs1_hazard = h1;  bus_s.rs1_hazard = h1;
      bus.rs2_hazard = h2;  bus_s.rs2_hazard = h2;
      bus.ex_stall   = es;  bus_s.ex_stall   = es;
   endtask

   task automatic idle();
      drv(1'b0, BrNone, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      resetn   = 1'b0;
      resetn_s = 1'b0;
      idle();
      tick();
      tick();
      resetn = 1'b1;
      chk("rst_redirect", 32'(bus.pc_redirect), 32'd0);
      chk("rst_flush", 32'(bus.flush_ifid), 32'd0);
      chk("rst_misalign", 32'(bus.misalign_exc), 32'd0);
      chk("rst_stall", 32'(bus.id_stall), 32'd0);
      chk("rst_target", bus.redirect_target, 32'h0);
      chk("rst_bcnt", bus.branch_cnt, 32'd0);
      chk("rst_tcnt", bus.taken_cnt, 32'd0);

      // BEQ taken, operands ready
      drv(1'b1, BrBeq, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0);
      #1 chk("beq_stall", 32'(bus.id_stall), 32'd0);
      tick();
      idle();
      chk("beq_redirect", 32'(bus.pc_redirect), 32'd1);
      chk("beq_flush", 32'(bus.flush_ifid), 32'd1);
      chk("beq_target", bus.redirect_target, 32'h120);
      chk("beq_bcnt", bus.branch_cnt, 32'd1);
      chk("beq_tcnt", bus.taken_cnt, 32'd1);
      tick();
      chk("beq_redirect_end", 32'(bus.pc_redirect), 32'd0);
      chk("beq_flush_end", 32'(bus.flush_ifid), 32'd0);

      // BLT signed taken
      drv(1'b1, BrBlt, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      chk("blt_redirect", 32'(bus.pc_redirect), 32'd1);
      chk("blt_target", bus.redirect_target, 32'h210);
      chk("blt_tcnt", bus.taken_cnt, 32'd2);
      tick();

      // BLTU same operands: not taken
      drv(1'b1, BrBltu, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      chk("bltu_redirect", 32'(bus.pc_redirect), 32'd0);
      chk("bltu_bcnt", bus.branch_cnt, 32'd3);
      chk("bltu_tcnt", bus.taken_cnt, 32'd2);
      tick();
      chk("bltu_redirect_late", 32'(bus.pc_redirect), 32'd0);

      // JALR with rs1 hazard for two cycles, misaligned target 0x202
      drv(1'b1, BrJalr, 32'h300, 32'h0, 32'h203, 32'h0, 1'b1, 1'b0, 1'b0);
      #1 chk("jalr_stall0", 32'(bus.id_stall), 32'd1);
      tick();
      chk("jalr_stall1", 32'(bus.id_stall), 32'd1);
      chk("jalr_bcnt_wait", bus.branch_cnt, 32'd3);
      tick();
      bus.rs1_hazard = 1'b0;
      bus_s.rs1_hazard = 1'b0;
      #1 chk("jalr_stall_clear", 32'(bus.id_stall), 32'd0);
      tick();
      idle();
      chk("jalr_misalign", 32'(bus.misalign_exc), 32'd1);
      chk("jalr_redirect", 32'(bus.pc_redirect), 32'd0);
      chk("jalr_bcnt", bus.branch_cnt, 32'd4);
      chk("jalr_tcnt", bus.taken_cnt, 32'd3);
      tick();
      chk("jalr_misalign_end", 32'(bus.misalign_exc), 32'd0);
      chk("jalr_redirect_late", 32'(bus.pc_redirect), 32'd0);

      // JAL backwards; a BNE shown during REDIRECT must be ignored
      drv(1'b1, BrJal, 32'h40, 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      #1 chk("jal_link", bus.link_pc, 32'h44);
      tick();
      drv(1'b1, BrBne, 32'h80, 32'h8, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
      chk("jal_redirect", 32'(bus.pc_redirect), 32'd1);
      chk("jal_target", bus.redirect_target, 32'h38);
      tick();
      idle();
      chk("jal_bne_ignored_redirect", 32'(bus.pc_redirect), 32'd0);
      chk("jal_bne_ignored_bcnt", bus.branch_cnt, 32'd5);
      chk("jal_tcnt", bus.taken_cnt, 32'd4);

      // BNE waiting on rs2; ex_stall holds resolution after the hazard clears
      drv(1'b1, BrBne, 32'h500, 32'h8, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0);
      #1 chk("bne_stall0", 32'(bus.id_stall), 32'd1);
      tick();
      bus.rs2_hazard = 1'b0;   bus_s.rs2_hazard = 1'b0;
      bus.ex_stall   = 1'b1;   bus_s.ex_stall   = 1'b1;
      #1 chk("bne_stall_exhold", 32'(bus.id_stall), 32'd1);
      tick();
      chk("bne_hold_redirect", 32'(bus.pc_redirect), 32'd0);
      chk("bne_hold_bcnt", bus.branch_cnt, 32'd5);
      chk("bne_hold_stall", 32'(bus.id_stall), 32'd1);
      bus.ex_stall = 1'b0;     bus_s.ex_stall = 1'b0;
      #1 chk("bne_stall_release", 32'(bus.id_stall), 32'd0);
      tick();
      idle();
      chk("bne_redirect", 32'(bus.pc_redirect), 32'd1);
      chk("bne_target", bus.redirect_target, 32'h508);
      chk("bne_bcnt", bus.branch_cnt, 32'd6);
      chk("bne_tcnt", bus.taken_cnt, 32'd5);
      tick();

      // Reset on the edge that would enter REDIRECT: no strobe, counters cleared
      drv(1'b1, BrJal, 32'h600, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      resetn = 1'b0;
      tick();
      chk("rstmid_redirect", 32'(bus.pc_redirect), 32'd0);
      chk("rstmid_flush", 32'(bus.flush_ifid), 32'd0);
      chk("rstmid_bcnt", bus.branch_cnt, 32'd0);
      chk("rstmid_tcnt", bus.taken_cnt, 32'd0);
      idle();
      resetn = 1'b1;
      tick();
      chk("rstmid_redirect_after", 32'(bus.pc_redirect), 32'd0);

      // Counter wrap on the 2-bit instance: four taken JALs return to zero
      resetn_s = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drv(1'b1, BrJal, 32'h700, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
         tick();
         idle();
         tick();
         if (i == 2) begin
            chk("wrap_bcnt_max", 32'(bus_s.branch_cnt), 32'd3);
            chk("wrap_tcnt_max", 32'(bus_s.taken_cnt), 32'd3);
         end
      end
      chk("wrap_bcnt", 32'(bus_s.branch_cnt), 32'd0);
      chk("wrap_tcnt", 32'(bus_s.taken_cnt), 32'd0);
      chk("nowrap_bcnt", bus.branch_cnt, 32'd4);
      chk("nowrap_target", bus.redirect_target, 32'h710);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
